// File: rtl/vga_rect_plotter.sv
// Rectangle draw engine feeding vga_adapter: one command in, one raster-order pixel per clock out.
// Optional PLOTTER_CLIP_EN suppresses plot for positions at or beyond SCREEN_W x SCREEN_H.
module vga_rect_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_mode,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     X,
  output logic [Y_W-1:0]     Y,
  output logic [COLOR_W-1:0] color
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_ready;
  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic [X_W-1:0]     r_w;
  logic [Y_W-1:0]     r_h;
  logic [COLOR_W-1:0] r_color;
  logic               r_mode;
  logic [X_W-1:0]     r_cx;
  logic [Y_W-1:0]     r_cy;
  logic               r_plot;
  logic [X_W-1:0]     r_X;
  logic [Y_W-1:0]     r_Y;
  logic [COLOR_W-1:0] r_pix_color;

  logic               w_accept;
  logic               w_empty;
  logic               w_row_end;
  logic               w_last;
  logic [X_W-1:0]     w_x0;
  logic [Y_W-1:0]     w_y0;
  logic [X_W-1:0]     w_w;
  logic [Y_W-1:0]     w_h;
  logic [COLOR_W-1:0] w_color;
  logic               w_mode;
  logic [X_W-1:0]     w_ncx;
  logic [Y_W-1:0]     w_ncy;
  logic               w_border;
  logic               w_clip;
  logic [X_W-1:0]     w_px;
  logic [Y_W-1:0]     w_py;
  logic               w_plot_next;
  logic               w_load;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid && r_ready;
  assign w_empty   = (cmd_w == '0) || (cmd_h == '0);
  assign w_row_end = (r_cx == r_w - 1'b1);
  assign w_last    = w_row_end && (r_cy == r_h - 1'b1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_empty ? S_DONE : S_DRAW;
      S_DRAW: if (w_last)   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // On accept the first pixel is computed straight from the command inputs,
  // so it is on the outputs the cycle after the handshake.
  always_comb begin
    w_x0    = r_x0;
    w_y0    = r_y0;
    w_w     = r_w;
    w_h     = r_h;
    w_color = r_color;
    w_mode  = r_mode;
    w_ncx   = w_row_end ? '0 : r_cx + 1'b1;
    w_ncy   = w_row_end ? r_cy + 1'b1 : r_cy;
    if (w_accept) begin
      w_x0    = cmd_x;
      w_y0    = cmd_y;
      w_w     = cmd_w;
      w_h     = cmd_h;
      w_color = cmd_color;
      w_mode  = cmd_mode;
      w_ncx   = '0;
      w_ncy   = '0;
    end
  end

  assign w_border = (w_ncx == '0) || (w_ncx == w_w - 1'b1) ||
                    (w_ncy == '0) || (w_ncy == w_h - 1'b1);
  assign w_px     = w_x0 + w_ncx;
  assign w_py     = w_y0 + w_ncy;

`ifdef PLOTTER_CLIP_EN
  logic [X_W:0] w_sum_x;
  logic [Y_W:0] w_sum_y;
  assign w_sum_x = {1'b0, w_x0} + {1'b0, w_ncx};
  assign w_sum_y = {1'b0, w_y0} + {1'b0, w_ncy};
  assign w_clip  = (w_sum_x >= (X_W+1)'(SCREEN_W)) || (w_sum_y >= (Y_W+1)'(SCREEN_H));
`else
  assign w_clip  = 1'b0;
`endif

  assign w_plot_next = (!w_mode || w_border) && !w_clip;
  assign w_load      = (w_next == S_DRAW);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ready     <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_mode      <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_plot      <= 1'b0;
      r_X         <= '0;
      r_Y         <= '0;
      r_pix_color <= '0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_x0    <= cmd_x;
        r_y0    <= cmd_y;
        r_w     <= cmd_w;
        r_h     <= cmd_h;
        r_color <= cmd_color;
        r_mode  <= cmd_mode;
      end
      if (w_load) begin
        r_cx        <= w_ncx;
        r_cy        <= w_ncy;
        r_X         <= w_px;
        r_Y         <= w_py;
        r_pix_color <= w_color;
        r_plot      <= w_plot_next;
      end else begin
        // X/Y/color keep the last scanned pixel while idle or completing
        r_cx   <= '0;
        r_cy   <= '0;
        r_plot <= 1'b0;
      end
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign plot      = r_plot;
  assign X         = r_X;
  assign Y         = r_Y;
  assign color     = r_pix_color;

endmodule
